// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - ID-side hazard/forwarding controller with EXE/MEM/WB shadow records
// Optional multi-cycle mul/div interlock is built when HAZARD_MD_EN is defined.
module hazard_forward_unit #(
  parameter int REG_AW = 5,
  parameter int NUM_RP = 2,
  parameter int MD_LAT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     id_valid,
  input  logic [NUM_RP*REG_AW-1:0] id_src,
  input  logic [NUM_RP-1:0]        id_src_used,
  input  logic [REG_AW-1:0]        id_wr_num,
  input  logic                     id_reg_write,
  input  logic                     id_is_load,
  input  logic                     id_is_md,
  input  logic                     id_uses_hilo,
  input  logic                     flush,
  output logic                     stall,
  output logic [NUM_RP-1:0]        id_bypass_wb,
  output logic [2*NUM_RP-1:0]      exe_fwd_sel,
  output logic                     md_busy
);

  // Shadow destination records; MEM/WB only need valid/reg_write/wr_num for matching.
  logic              exe_valid_q, exe_valid_d;
  logic [REG_AW-1:0] exe_wr_q, exe_wr_d;
  logic              exe_rw_q, exe_rw_d;
  logic              exe_ld_q, exe_ld_d;
  logic              mem_valid_q;
  logic [REG_AW-1:0] mem_wr_q;
  logic              mem_rw_q;
  logic              wb_valid_q;
  logic [REG_AW-1:0] wb_wr_q;
  logic              wb_rw_q;
  logic [2*NUM_RP-1:0] fwd_q, fwd_d;

  logic [REG_AW-1:0] src [NUM_RP];
  logic [NUM_RP-1:0] m_exe, m_mem, m_wb;
  logic              lu_hazard;
  logic              md_hazard;
  logic              accept;

  function automatic logic slot_match(input logic v, input logic rw,
                                      input logic [REG_AW-1:0] wr,
                                      input logic [REG_AW-1:0] s);
    return v && rw && (wr == s) && (s != '0);
  endfunction

  always_comb begin
    for (int p = 0; p < NUM_RP; p++) begin
      src[p]   = id_src[p*REG_AW +: REG_AW];
      m_exe[p] = id_src_used[p] && slot_match(exe_valid_q, exe_rw_q, exe_wr_q, src[p]);
      m_mem[p] = id_src_used[p] && slot_match(mem_valid_q, mem_rw_q, mem_wr_q, src[p]);
      m_wb[p]  = id_src_used[p] && slot_match(wb_valid_q, wb_rw_q, wb_wr_q, src[p]);
    end
  end

  assign lu_hazard    = id_valid && exe_ld_q && (|m_exe);
  assign stall        = !flush && (lu_hazard || md_hazard);
  assign accept       = id_valid && !stall && !flush;
  assign id_bypass_wb = m_wb;
  assign exe_fwd_sel  = fwd_q;

  always_comb begin
    exe_valid_d = accept;
    exe_wr_d    = accept ? id_wr_num : '0;
    exe_rw_d    = accept && id_reg_write;
    exe_ld_d    = accept && id_is_load;
    fwd_d       = '0;
    // EXE holds the youngest writer, so it wins over MEM.
    for (int p = 0; p < NUM_RP; p++) begin
      if (accept && m_exe[p] && !exe_ld_q) begin
        fwd_d[2*p +: 2] = 2'b01;
      end else if (accept && m_mem[p]) begin
        fwd_d[2*p +: 2] = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exe_valid_q <= 1'b0;
      exe_wr_q    <= '0;
      exe_rw_q    <= 1'b0;
      exe_ld_q    <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_wr_q    <= '0;
      mem_rw_q    <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_wr_q     <= '0;
      wb_rw_q     <= 1'b0;
      fwd_q       <= '0;
    end else begin
      exe_valid_q <= exe_valid_d;
      exe_wr_q    <= exe_wr_d;
      exe_rw_q    <= exe_rw_d;
      exe_ld_q    <= exe_ld_d;
      mem_valid_q <= exe_valid_q;
      mem_wr_q    <= exe_wr_q;
      mem_rw_q    <= exe_rw_q;
      wb_valid_q  <= mem_valid_q;
      wb_wr_q     <= mem_wr_q;
      wb_rw_q     <= mem_rw_q;
      fwd_q       <= fwd_d;
    end
  end

`ifdef HAZARD_MD_EN
  localparam int CW = $clog2(MD_LAT + 1);
  logic [CW-1:0] md_cnt_q, md_cnt_d;

  // Keeps counting while stalled or flushed; only a new accepted MD reloads it.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (accept && id_is_md) begin
      md_cnt_d = CW'(MD_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign md_busy   = (md_cnt_q != '0);
  assign md_hazard = id_valid && (id_is_md || id_uses_hilo) && md_busy;
`else
  logic unused_md_inputs;
  assign unused_md_inputs = ^{id_is_md, id_uses_hilo};
  assign md_busy          = 1'b0;
  assign md_hazard        = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb/tb_hazard_forward_unit.sv - directed-vector bench for hazard_forward_unit
module tb_hazard_forward_unit;

  localparam int REG_AW = 5;
  localparam int NUM_RP = 2;
  localparam int MD_LAT = 4;
`ifdef HAZARD_MD_EN
  localparam logic MD_ON = 1'b1;
`else
  localparam logic MD_ON = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     id_valid = 1'b0;
  logic [NUM_RP*REG_AW-1:0] id_src = '0;
  logic [NUM_RP-1:0]        id_src_used = '0;
  logic [REG_AW-1:0]        id_wr_num = '0;
  logic                     id_reg_write = 1'b0;
  logic                     id_is_load = 1'b0;
  logic                     id_is_md = 1'b0;
  logic                     id_uses_hilo = 1'b0;
  logic                     flush = 1'b0;
  logic                     stall;
  logic [NUM_RP-1:0]        id_bypass_wb;
  logic [2*NUM_RP-1:0]      exe_fwd_sel;
  logic                     md_busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  hazard_forward_unit #(.REG_AW(REG_AW), .NUM_RP(NUM_RP), .MD_LAT(MD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_src(id_src),
    .id_src_used(id_src_used), .id_wr_num(id_wr_num), .id_reg_write(id_reg_write),
    .id_is_load(id_is_load), .id_is_md(id_is_md), .id_uses_hilo(id_uses_hilo),
    .flush(flush), .stall(stall), .id_bypass_wb(id_bypass_wb),
    .exe_fwd_sel(exe_fwd_sel), .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic set_id(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] used, input logic [4:0] wr, input logic rw,
                        input logic ld, input logic md, input logic hilo);
    id_valid     = v;
    id_src       = {s1, s0};
    id_src_used  = used;
    id_wr_num    = wr;
    id_reg_write = rw;
    id_is_load   = ld;
    id_is_md     = md;
    id_uses_hilo = hilo;
    #1;
  endtask

  task automatic idle();
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle();
    flush = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle();
    step();
    step();
    vec_cnt++;
    if ({stall, md_busy, id_bypass_wb, exe_fwd_sel} !== 8'h00) begin
      err_cnt++;
      $display("FAIL reset_outputs: got %b want 00000000", {stall, md_busy, id_bypass_wb, exe_fwd_sel});
    end
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_exe_forward();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0); // ADD $3
    step();
    set_id(1'b1, 5'd3, 5'd5, 2'b11, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0); // SUB $4,$3,$5
    vec_cnt++;
    if (stall !== 1'b0) begin
      err_cnt++;
      $display("FAIL exe_fwd_stall: got %b want 0", stall);
    end
    step();
    idle();
    vec_cnt++;
    if (exe_fwd_sel !== 4'b0001) begin
      err_cnt++;
      $display("FAIL exe_fwd_sel: got %b want 0001", exe_fwd_sel);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0); // LW $8
    step();
    set_id(1'b1, 5'd8, 5'd8, 2'b11, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0); // ADD $9,$8,$8
    vec_cnt++;
    if (stall !== 1'b1) begin
      err_cnt++;
      $display("FAIL load_use_stall: got %b want 1", stall);
    end
    step();
    vec_cnt++;
    if ({stall, exe_fwd_sel} !== 5'b00000) begin
      err_cnt++;
      $display("FAIL load_use_bubble: got %b want 00000", {stall, exe_fwd_sel});
    end
    step();
    idle();
    vec_cnt++;
    if (exe_fwd_sel !== 4'b1010) begin
      err_cnt++;
      $display("FAIL load_use_sel: got %b want 1010", exe_fwd_sel);
    end
  endtask

  task automatic test_reg_zero();
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0); // LW $0
    step();
    set_id(1'b1, 5'd0, 5'd0, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    vec_cnt++;
    if ({stall, id_bypass_wb} !== 3'b000) begin
      err_cnt++;
      $display("FAIL zero_stall_bypass: got %b want 000", {stall, id_bypass_wb});
    end
    step();
    idle();
    vec_cnt++;
    if (exe_fwd_sel !== 4'b0000) begin
      err_cnt++;
      $display("FAIL zero_sel: got %b want 0000", exe_fwd_sel);
    end
    step();
    set_id(1'b1, 5'd0, 5'd0, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    vec_cnt++;
    if (id_bypass_wb !== 2'b00) begin
      err_cnt++;
      $display("FAIL zero_wb_bypass: got %b want 00", id_bypass_wb);
    end
  endtask

  task automatic test_wb_bypass();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    set_id(1'b1, 5'd6, 5'd9, 2'b11, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    vec_cnt++;
    if (id_bypass_wb !== 2'b01) begin
      err_cnt++;
      $display("FAIL wb_bypass: got %b want 01", id_bypass_wb);
    end
    set_id(1'b1, 5'd6, 5'd6, 2'b00, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0);
    vec_cnt++;
    if (id_bypass_wb !== 2'b00) begin
      err_cnt++;
      $display("FAIL wb_bypass_unused: got %b want 00", id_bypass_wb);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    set_id(1'b1, 5'd1, 5'd7, 2'b11, 5'd15, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    vec_cnt++;
    if (exe_fwd_sel !== 4'b1000) begin
      err_cnt++;
      $display("FAIL mem_fwd_port1: got %b want 1000", exe_fwd_sel);
    end
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    step();
    set_id(1'b1, 5'd7, 5'd7, 2'b11, 5'd16, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    vec_cnt++;
    if (exe_fwd_sel !== 4'b0101) begin
      err_cnt++;
      $display("FAIL exe_over_mem: got %b want 0101", exe_fwd_sel);
    end
  endtask

  task automatic test_md();
    do_reset();
    set_id(1'b1, 5'd1, 5'd2, 2'b11, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0); // MULT
    step();
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1); // MFLO
    for (int i = 0; i < MD_LAT; i++) begin
      flush = (i == 1);
      #1;
      vec_cnt++;
      if ({stall, md_busy} !== {MD_ON && (i != 1), MD_ON}) begin
        err_cnt++;
        $display("FAIL md_busy_cycle%0d: got %b want %b", i, {stall, md_busy}, {MD_ON && (i != 1), MD_ON});
      end
      step();
    end
    flush = 1'b0;
    #1;
    vec_cnt++;
    if ({stall, md_busy} !== 2'b00) begin
      err_cnt++;
      $display("FAIL md_release: got %b want 00", {stall, md_busy});
    end
    idle();
  endtask

  task automatic test_flush_reset();
    do_reset();
    set_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0); // LW $2
    step();
    set_id(1'b1, 5'd2, 5'd0, 2'b01, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0);
    flush = 1'b1;
    #1;
    vec_cnt++;
    if (stall !== 1'b0) begin
      err_cnt++;
      $display("FAIL flush_stall: got %b want 0", stall);
    end
    step();
    flush = 1'b0;
    set_id(1'b1, 5'd13, 5'd0, 2'b01, 5'd17, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    idle();
    vec_cnt++;
    if (exe_fwd_sel !== 4'b0000) begin
      err_cnt++;
      $display("FAIL flush_bubble: got %b want 0000", exe_fwd_sel);
    end
    set_id(1'b1, 5'd1, 5'd0, 2'b01, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    set_id(1'b1, 5'd2, 5'd2, 2'b11, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0);
    vec_cnt++;
    if (stall !== 1'b1) begin
      err_cnt++;
      $display("FAIL pre_reset_stall: got %b want 1", stall);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({stall, md_busy, id_bypass_wb, exe_fwd_sel} !== 8'h00) begin
      err_cnt++;
      $display("FAIL async_reset: got %b want 00000000", {stall, md_busy, id_bypass_wb, exe_fwd_sel});
    end
    rst_n = 1'b1;
    step();
    vec_cnt++;
    if ({stall, exe_fwd_sel} !== 5'b00000) begin
      err_cnt++;
      $display("FAIL post_reset_empty: got %b want 00000", {stall, exe_fwd_sel});
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_exe_forward();
    test_load_use();
    test_reg_zero();
    test_wb_bypass();
    test_back_to_back();
    test_md();
    test_flush_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
# hazard_forward_unit

Parametrised hazard and forwarding controller for the five-stage MIPS pipeline. It sits beside the ID stage and keeps its own shadow pipeline of destination-register records for EXE, MEM and WB. From that it produces registered EXE-stage forwarding selects, a combinational ID-stage write-back bypass, and the pipeline stall for load-use and multi-cycle mul/div hazards. It supersedes the purely combinational forwarding logic, which cannot see loads or multi-cycle units.

## Interface
Parameters:
- REG_AW, 5, register-number width
- NUM_RP, 2, number of source-operand read ports
- MD_LAT, 4, mul/div busy cycles after issue; must be at least 1

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_src  in  NUM_RP*REG_AW  source register numbers; port p is bits [p*REG_AW +: REG_AW]
- id_src_used  in  NUM_RP  port p actually reads id_src[p]
- id_wr_num  in  REG_AW  ID destination register
- id_reg_write  in  1  ID instruction writes the register file
- id_is_load  in  1  ID instruction is a load (LW)
- id_is_md  in  1  ID instruction issues mul/div
- id_uses_hilo  in  1  ID instruction reads HI/LO (MFHI/MFLO)
- flush  in  1  kill the ID instruction (branch/jump redirect)
- stall  out  1  freeze PC and IF/ID; combinational
- id_bypass_wb  out  NUM_RP  port p takes WB write data instead of the register-file value; combinational
- exe_fwd_sel  out  2*NUM_RP  registered EXE operand select: 00 register value carried in EXE, 01 MEM-stage ALU result, 10 WB write data, 11 reserved
- md_busy  out  1  mul/div unit occupied

## Operation
- Shadow slots are EXE, MEM and WB, each holding {valid, wr_num, reg_write, is_load}.
- A slot "matches" source s when: slot valid, slot reg_write set, wr_num == s, and s != 0. Register 0 never matches.
- Load-use hazard: id_valid, any used port matches the EXE slot, and the EXE slot is_load.
- MD hazard: id_valid, (id_is_md or id_uses_hilo), and md_busy.
- stall = !flush and (load-use hazard or MD hazard).
- Each cycle MEM shifts into WB and EXE shifts into MEM.
- The EXE slot loads the ID record when id_valid, !stall and !flush. Otherwise it loads a bubble (valid = 0).
- Per port, exe_fwd_sel captures the following when the ID record is accepted:
  - 01 if the port matches the EXE slot and that slot is not a load;
  - else 10 if the port matches the MEM slot;
  - else 00.
  - The EXE slot has priority over MEM because it is the youngest writer.
  - Unused ports and bubbles capture 00.
- id_bypass_wb[p] = id_src_used[p] and port p matches the WB slot. This covers the same-cycle write/read case.
- MD counter (width $clog2(MD_LAT+1)):
  - Loads MD_LAT when an id_is_md instruction is accepted into EXE.
  - Otherwise decrements while nonzero. It counts during stall.
  - md_busy = (counter != 0).

## Timing
- Reset (asynchronous, rst_n low): all slots invalid, exe_fwd_sel = 0, counter = 0. As a result stall = 0, md_busy = 0, id_bypass_wb = 0.
- Forwarding select latency: one cycle, computed in ID and valid throughout the instruction's EXE cycle.
- A load-use stall lasts exactly one cycle: the next cycle the load is in MEM and the select resolves to 10.
- After MD issue in cycle t, md_busy is high in cycles t+1 through t+MD_LAT. A dependent MFHI/MFLO or second MD is accepted at cycle t+MD_LAT+1.
- flush together with a hazard: stall is low and a bubble enters EXE. flush during md_busy does not clear the counter.
- Deasserting reset mid-operation resumes from the empty state. No partial records survive.

## Configuration
- HAZARD_MD_EN defined: MD counter, MD hazard and md_busy are implemented as above.
- Not defined: no counter is built, md_busy ties to 0, and id_is_md / id_uses_hilo are ignored.

## Test plan
- ADD $3 then SUB $4,$3,$5 back-to-back -> SUB's exe_fwd_sel port0 = 01, no stall.
- LW $8 then ADD $9,$8,$8 -> stall high one cycle, bubble in EXE, then exe_fwd_sel = {10,10}.
- Writer of $0 followed by reader of $0 -> no stall, selects 00, id_bypass_wb = 0.
- Writer to $6, two unrelated instructions, then reader of $6 in ID while the writer is in WB -> id_bypass_wb[0] = 1.
- MULT at cycle 10 (MD_LAT = 4), MFLO in ID from cycle 11 -> stall cycles 11-14, MFLO accepted at cycle 15. With HAZARD_MD_EN undefined -> no stall.
- LW $2 in EXE, dependent instruction in ID, flush asserted, then rst_n pulsed low mid-sequence -> stall 0, bubble inserted, all outputs return to 0 immediately on reset.
